// File: rtl/ann_net_pkg.sv
// rtl/ann_net_pkg.sv - shared constants, state encoding and neuron arithmetic for ann_net
// ANN_NET_ACT_EN selects hard-sigmoid activation; undefined gives identity activation.
package ann_net_pkg;

    localparam int WORD_W  = 16;
    localparam int N_IN    = 7;
    localparam int N_HID   = 15;
    localparam int N_OUT   = 2;
    localparam int Q_SHIFT = 8;
    localparam int PROD_W  = 2 * WORD_W;
    localparam int ACC_W   = 2 * WORD_W + 4;

    localparam logic signed [WORD_W-1:0] ACT_BIAS = 16'sh0080;
    localparam logic signed [WORD_W-1:0] ACT_MAX  = 16'sh0100;
    localparam logic signed [WORD_W-1:0] SAT_MAX  = 16'sh7FFF;
    localparam logic signed [WORD_W-1:0] SAT_MIN  = 16'sh8000;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [2:0] {IDLE, HID, HACT, OUT, OACT, DONE} state_t;

    function automatic logic signed [WORD_W-1:0] sat_word(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> Q_SHIFT;
        if (sh > ACC_W'(SAT_MAX)) return SAT_MAX;
        if (sh < ACC_W'(SAT_MIN)) return SAT_MIN;
        return sh[WORD_W-1:0];
    endfunction

    function automatic logic signed [WORD_W-1:0] act_fn(input logic signed [WORD_W-1:0] s);
`ifdef ANN_NET_ACT_EN
        logic signed [WORD_W-1:0] t;
        // s>>>2 stays within +-0x2000, so adding the bias cannot wrap
        t = (s >>> 2) + ACT_BIAS;
        if (t[WORD_W-1]) return '0;
        if (t > ACT_MAX) return ACT_MAX;
        return t;
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/ann_net_if.sv
// rtl/ann_net_if.sv - input vector, result and weight-preload signals of ann_net
interface ann_net_if;
    import ann_net_pkg::*;

    logic                     in_rdy;
    logic signed [WORD_W-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic signed [WORD_W-1:0] data_in_4, data_in_5, data_in_6;
    logic signed [WORD_W-1:0] net_out_0, net_out_1;
    logic                     net_rdy;
    logic                     wt_we;
    logic [4:0]               wt_sel;
    logic [3:0]               wt_addr;
    logic [WORD_W-1:0]        wt_data;

    modport master (
        output in_rdy, data_in_0, data_in_1, data_in_2, data_in_3, data_in_4, data_in_5, data_in_6,
        output wt_we, wt_sel, wt_addr, wt_data,
        input  net_out_0, net_out_1, net_rdy
    );

    modport slave (
        input  in_rdy, data_in_0, data_in_1, data_in_2, data_in_3, data_in_4, data_in_5, data_in_6,
        input  wt_we, wt_sel, wt_addr, wt_data,
        output net_out_0, net_out_1, net_rdy
    );
endinterface

// File: rtl/ann_neuron.sv
// rtl/ann_neuron.sv - serial MAC neuron with private weight RAM, saturation and activation
module ann_neuron
    import ann_net_pkg::*;
#(
    parameter int FAN_IN = N_IN,
    parameter int AW     = $clog2(FAN_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     mac,
    input  logic                     act,
    input  logic [AW-1:0]            idx,
    input  logic signed [WORD_W-1:0] x,
    input  logic                     wt_we,
    input  logic [AW-1:0]            wt_addr,
    input  logic [WORD_W-1:0]        wt_data,
    output logic signed [WORD_W-1:0] y
);
    if (1) begin : DF
        // weights survive reset; word address equals the input index
        if (1) begin : WRAM
            logic [WORD_W-1:0] mem [FAN_IN];
            always_ff @(posedge clk) begin
                if (wt_we) mem[wt_addr] <= wt_data;
            end
        end

        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  acc_q, acc_d;
        logic signed [WORD_W-1:0] y_q, y_d;

        always_comb begin
            prod  = PROD_W'(x) * PROD_W'($signed(WRAM.mem[idx]));
            acc_d = acc_q;
            y_d   = y_q;
            if (clr)      acc_d = '0;
            else if (mac) acc_d = acc_q + ACC_W'(prod);
            if (act)      y_d = act_fn(sat_word(acc_q));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
                y_q   <= '0;
            end else begin
                acc_q <= acc_d;
                y_q   <= y_d;
            end
        end
    end

    assign y = DF.y_q;
endmodule

// File: rtl/ann_net.sv
// rtl/ann_net.sv - 7-15-2 fixed-point feed-forward network; ANN_NET_ACT_EN selects hard sigmoid
module ann_net
    import ann_net_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    ann_net_if.slave bus
);
    localparam int N_NEUR = N_HID + N_OUT;

    state_t                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic                     in_rdy_q, in_rdy_d;
    logic                     net_rdy_q, net_rdy_d;
    logic signed [WORD_W-1:0] x_q [N_IN];
    logic signed [WORD_W-1:0] x_d [N_IN];
    logic                     start, hid_mac, hid_act, out_mac, out_act;
    logic signed [WORD_W-1:0] hid_x, out_x;
    logic signed [WORD_W-1:0] hid_y [N_HID];
    logic signed [WORD_W-1:0] out_y [N_OUT];
    logic [N_NEUR-1:0]        wt_we;

    assign hid_mac = (state_q == HID);
    assign hid_act = (state_q == HACT);
    assign out_mac = (state_q == OUT);
    assign out_act = (state_q == OACT);
    assign hid_x   = x_q[idx_q[2:0]];
    assign out_x   = hid_y[idx_q];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        net_rdy_d = net_rdy_q;
        in_rdy_d  = bus.in_rdy;
        start     = (bus.in_rdy == HIGH) && (in_rdy_q == LOW) && (state_q == IDLE || state_q == DONE);
        case (state_q)
            HID: begin
                if (idx_q == 4'(N_IN - 1)) begin
                    state_d = HACT;
                    idx_d   = '0;
                end else idx_d = idx_q + 4'd1;
            end
            HACT: state_d = OUT;
            OUT: begin
                if (idx_q == 4'(N_HID - 1)) begin
                    state_d = OACT;
                    idx_d   = '0;
                end else idx_d = idx_q + 4'd1;
            end
            OACT: begin
                state_d   = DONE;
                net_rdy_d = HIGH;
            end
            default: ;
        endcase
        // old outputs stay visible until OACT; only net_rdy drops on a restart
        if (start) begin
            state_d   = HID;
            idx_d     = '0;
            net_rdy_d = LOW;
            x_d[0] = bus.data_in_0;  x_d[1] = bus.data_in_1;  x_d[2] = bus.data_in_2;
            x_d[3] = bus.data_in_3;  x_d[4] = bus.data_in_4;  x_d[5] = bus.data_in_5;
            x_d[6] = bus.data_in_6;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_rdy_q  <= LOW;
            net_rdy_q <= LOW;
            x_q       <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_rdy_q  <= in_rdy_d;
            net_rdy_q <= net_rdy_d;
            x_q       <= x_d;
        end
    end

    always_comb begin
        wt_we = '0;
        if (bus.wt_we) wt_we[bus.wt_sel] = 1'b1;
    end

    ann_neuron #(.FAN_IN(N_IN)) h0 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[0]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[0]));
    ann_neuron #(.FAN_IN(N_IN)) h1 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[1]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[1]));
    ann_neuron #(.FAN_IN(N_IN)) h2 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[2]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[2]));
    ann_neuron #(.FAN_IN(N_IN)) h3 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[3]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[3]));
    ann_neuron #(.FAN_IN(N_IN)) h4 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[4]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[4]));
    ann_neuron #(.FAN_IN(N_IN)) h5 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[5]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[5]));
    ann_neuron #(.FAN_IN(N_IN)) h6 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[6]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[6]));
    ann_neuron #(.FAN_IN(N_IN)) h7 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[7]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[7]));
    ann_neuron #(.FAN_IN(N_IN)) h8 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[8]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[8]));
    ann_neuron #(.FAN_IN(N_IN)) h9 (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[9]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[9]));
    ann_neuron #(.FAN_IN(N_IN)) ha (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[10]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[10]));
    ann_neuron #(.FAN_IN(N_IN)) hb (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[11]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[11]));
    ann_neuron #(.FAN_IN(N_IN)) hc (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[12]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[12]));
    ann_neuron #(.FAN_IN(N_IN)) hd (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[13]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[13]));
    ann_neuron #(.FAN_IN(N_IN)) he (.clk, .reset, .clr(start), .mac(hid_mac), .act(hid_act), .idx(idx_q[2:0]), .x(hid_x), .wt_we(wt_we[14]), .wt_addr(bus.wt_addr[2:0]), .wt_data(bus.wt_data), .y(hid_y[14]));

    ann_neuron #(.FAN_IN(N_HID)) o0 (.clk, .reset, .clr(start), .mac(out_mac), .act(out_act), .idx(idx_q), .x(out_x), .wt_we(wt_we[15]), .wt_addr(bus.wt_addr), .wt_data(bus.wt_data), .y(out_y[0]));
    ann_neuron #(.FAN_IN(N_HID)) o1 (.clk, .reset, .clr(start), .mac(out_mac), .act(out_act), .idx(idx_q), .x(out_x), .wt_we(wt_we[16]), .wt_addr(bus.wt_addr), .wt_data(bus.wt_data), .y(out_y[1]));

    assign bus.net_out_0 = out_y[0];
    assign bus.net_out_1 = out_y[1];
    assign bus.net_rdy   = net_rdy_q;
endmodule

// File: tb/tb_ann_net.sv
// tb/tb_ann_net.sv - table-driven scoreboard bench for ann_net; expectations follow ANN_NET_ACT_EN
module tb_ann_net;
    typedef logic signed [15:0] word_t;
    typedef struct { word_t o0; word_t o1; } res_t;
    typedef struct { word_t x; word_t hw; word_t ow; bit rnd; word_t e0; word_t e1; } vec_t;

`ifdef ANN_NET_ACT_EN
    localparam word_t E_ZERO = 16'sh0080, E_UNIT = 16'sh0100, E_POS = 16'sh0100, E_NEG = 16'sh0080, E_MINUS = 16'sh0080;
`else
    localparam word_t E_ZERO = 16'sh0000, E_UNIT = 16'sh0690, E_POS = 16'sh7FFF, E_NEG = 16'sh8000, E_MINUS = 16'sh9700;
`endif

    logic clk = 1'b0;
    logic reset;
    ann_net_if bus ();
    ann_net dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    word_t hw_cur [15][7];
    word_t ow_cur [2][15];
    res_t  sb [$];
    res_t  last_res;
    int    total = 0;
    int    passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic word_t rnd_word(input int mag);
        return word_t'(int'($urandom_range(0, 2 * mag)) - mag);
    endfunction

    function automatic word_t m_neuron(input longint acc);
        longint s;
        s = acc >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef ANN_NET_ACT_EN
        s = (s >>> 2) + 128;
        if (s < 0) s = 0;
        else if (s > 256) s = 256;
`endif
        return word_t'(s);
    endfunction

    task automatic model(input word_t xv [7], output res_t r);
        word_t  h [15];
        longint acc;
        for (int k = 0; k < 15; k++) begin
            acc = 0;
            for (int i = 0; i < 7; i++) acc += longint'(xv[i]) * longint'(hw_cur[k][i]);
            h[k] = m_neuron(acc);
        end
        acc = 0;
        for (int k = 0; k < 15; k++) acc += longint'(h[k]) * longint'(ow_cur[0][k]);
        r.o0 = m_neuron(acc);
        acc = 0;
        for (int k = 0; k < 15; k++) acc += longint'(h[k]) * longint'(ow_cur[1][k]);
        r.o1 = m_neuron(acc);
    endtask

    task automatic set_weights(input word_t hw, input word_t ow, input bit rnd);
        for (int k = 0; k < 15; k++)
            for (int i = 0; i < 7; i++) hw_cur[k][i] = rnd ? rnd_word(256) : hw;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 15; k++) ow_cur[j][k] = rnd ? rnd_word(256) : ow;
        bus.wt_we = 1'b1;
        for (int k = 0; k < 15; k++)
            for (int i = 0; i < 7; i++) begin
                bus.wt_sel = 5'(k); bus.wt_addr = 4'(i); bus.wt_data = hw_cur[k][i];
                @(negedge clk);
            end
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 15; k++) begin
                bus.wt_sel = 5'(15 + j); bus.wt_addr = 4'(k); bus.wt_data = ow_cur[j][k];
                @(negedge clk);
            end
        bus.wt_we = 1'b0;
    endtask

    task automatic drive_x(input word_t xv [7]);
        bus.data_in_0 = xv[0]; bus.data_in_1 = xv[1]; bus.data_in_2 = xv[2]; bus.data_in_3 = xv[3];
        bus.data_in_4 = xv[4]; bus.data_in_5 = xv[5]; bus.data_in_6 = xv[6];
    endtask

    task automatic run_inf(input word_t xv [7], input res_t e, input bit busy_toggle);
        res_t  exp_e;
        word_t alt [7];
        int    n;
        bit    seen;
        bus.in_rdy = 1'b0;
        @(negedge clk);
        drive_x(xv);
        sb.push_back(e);
        bus.in_rdy = 1'b1;
        @(negedge clk);
        bus.in_rdy = 1'b0;
        chk("rdy_drop", 32'(bus.net_rdy), 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (busy_toggle && n == 4) begin
                for (int i = 0; i < 7; i++) alt[i] = ~xv[i];
                drive_x(alt);
                bus.in_rdy = 1'b1;
            end
            if (busy_toggle && n == 6) bus.in_rdy = 1'b0;
            if (n == 12) begin
                chk("hold_out_0", bus.net_out_0, last_res.o0);
                chk("hold_out_1", bus.net_out_1, last_res.o1);
            end
            seen = bus.net_rdy;
        end
        chk("latency", n, 24);
        exp_e = sb.pop_front();
        chk("net_out_0", bus.net_out_0, exp_e.o0);
        chk("net_out_1", bus.net_out_1, exp_e.o1);
        last_res = exp_e;
    endtask

    vec_t  vt [8];
    word_t xv [7];
    res_t  e;
    int    rises, rise_at;
    bit    prev;

    initial begin
        vt[0] = '{x: 16'sh0123, hw: 16'sh0000, ow: 16'sh0000, rnd: 1'b0, e0: E_ZERO,  e1: E_ZERO};
        vt[1] = '{x: 16'sh0010, hw: 16'sh0100, ow: 16'sh0100, rnd: 1'b0, e0: E_UNIT,  e1: E_UNIT};
        vt[2] = '{x: 16'sh7FFF, hw: 16'sh7FFF, ow: 16'sh7FFF, rnd: 1'b0, e0: E_POS,   e1: E_POS};
        vt[3] = '{x: 16'sh7FFF, hw: 16'sh8000, ow: 16'sh7FFF, rnd: 1'b0, e0: E_NEG,   e1: E_NEG};
        vt[4] = '{x: 16'shFF00, hw: 16'sh0100, ow: 16'sh0100, rnd: 1'b0, e0: E_MINUS, e1: E_MINUS};
        for (int r = 5; r < 8; r++) vt[r] = '{x: 16'sh0000, hw: 16'sh0000, ow: 16'sh0000, rnd: 1'b1, e0: 16'sh0000, e1: 16'sh0000};

        reset = 1'b1;
        bus.in_rdy = 1'b0; bus.wt_we = 1'b0; bus.wt_sel = '0; bus.wt_addr = '0; bus.wt_data = '0;
        for (int i = 0; i < 7; i++) xv[i] = 16'sh0000;
        drive_x(xv);
        last_res = '{16'sh0000, 16'sh0000};
        repeat (3) @(negedge clk);
        chk("reset_out_0", bus.net_out_0, 32'd0);
        chk("reset_out_1", bus.net_out_1, 32'd0);
        chk("reset_rdy", 32'(bus.net_rdy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            set_weights(vt[r].hw, vt[r].ow, vt[r].rnd);
            for (int i = 0; i < 7; i++) xv[i] = vt[r].rnd ? rnd_word(512) : vt[r].x;
            if (vt[r].rnd) model(xv, e);
            else e = '{vt[r].e0, vt[r].e1};
            run_inf(xv, e, 1'b0);
        end

        for (int i = 0; i < 7; i++) xv[i] = rnd_word(512);
        model(xv, e);
        run_inf(xv, e, 1'b1);

        // in_rdy already high when reset releases, then held for 100 cycles
        reset = 1'b1;
        for (int i = 0; i < 7; i++) xv[i] = 16'sh0040 + word_t'(i);
        drive_x(xv);
        model(xv, e);
        bus.in_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("held_reset_rdy", 32'(bus.net_rdy), 32'd0);
        reset = 1'b0;
        rises = 0; rise_at = 0; prev = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (bus.net_rdy && !prev) begin
                rises++;
                if (rise_at == 0) rise_at = t;
            end
            prev = bus.net_rdy;
        end
        chk("held_rises", rises, 1);
        chk("held_rise_at", rise_at, 25);
        chk("held_rdy", 32'(bus.net_rdy), 32'd1);
        chk("held_out_0", bus.net_out_0, e.o0);
        chk("held_out_1", bus.net_out_1, e.o1);
        bus.in_rdy = 1'b0;
        last_res = e;

        set_weights(16'sh0100, 16'sh0100, 1'b0);
        for (int i = 0; i < 7; i++) xv[i] = 16'sh0010;
        run_inf(xv, '{E_UNIT, E_UNIT}, 1'b0);
        for (int i = 0; i < 7; i++) xv[i] = 16'sh0020;
        drive_x(xv);
        bus.in_rdy = 1'b1;
        @(negedge clk);
        bus.in_rdy = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_0", bus.net_out_0, 32'd0);
        chk("midrst_out_1", bus.net_out_1, 32'd0);
        chk("midrst_rdy", 32'(bus.net_rdy), 32'd0);
        reset = 1'b0;
        last_res = '{16'sh0000, 16'sh0000};
        model(xv, e);
        run_inf(xv, e, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
